// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM BIST sequencer.
//   state_e      : sequencer states
//   PAT_*        : pattern_sel codes
//   BIST_ADDR_W  : default RAM address width
//   BIST_DATA_W  : default RAM word width
package ram_bist_pkg;

  localparam int BIST_ADDR_W = 6;
  localparam int BIST_DATA_W = 512;

  localparam logic [1:0] PAT_ZERO  = 2'd0;
  localparam logic [1:0] PAT_ONE   = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_ADDR  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_FINISH
  } state_e;

endpackage

// File: rtl/ram_bist_patgen.sv
// Combinational test-pattern generator.
//   addr_i : word address the pattern is generated for
//   sel_i  : pattern code (PAT_*)
//   pat_o  : full-width data word
module ram_bist_patgen
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DATA_W = BIST_DATA_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        sel_i,
  output logic [DATA_W-1:0] pat_o
);

  always_comb begin
    pat_o = '0;
    for (int k = 0; k < DATA_W / 8; k++) begin
      case (sel_i)
        PAT_ZERO:  pat_o[8*k +: 8] = 8'h00;
        PAT_ONE:   pat_o[8*k +: 8] = 8'hFF;
        PAT_CHECK: pat_o[8*k +: 8] = addr_i[0] ? 8'h55 : 8'hAA;
        default:   pat_o[8*k +: 8] = 8'(addr_i) ^ 8'(k);
      endcase
    end
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM built-in self-test sequencer: fills the RAM through port 1, reads it
// back through port 2 and counts mismatching words.
//   clk, reset_n               : clock, async active-low reset
//   start, pattern_sel         : test request and pattern code
//   busy, done, pass           : status
//   err_count, first_err_addr  : result of the last test
//   address..byteenable        : RAM port 1 (write only)
//   address2..byteenable2      : RAM port 2 (read only), readdata2 its data
//
// state    | meaning
// S_IDLE   | RAM idle, waiting for start
// S_WRITE  | writing pattern to every address
// S_READ   | issuing reads to every address
// S_DRAIN  | compare of the last read word
// S_FINISH | done pulse, pass valid
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DATA_W = BIST_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [1:0]          pattern_sel,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   address,
  output logic                chipselect,
  output logic                write,
  output logic                clken,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  output logic [ADDR_W-1:0]   address2,
  output logic                chipselect2,
  output logic                write2,
  output logic                clken2,
  output logic [DATA_W-1:0]   writedata2,
  output logic [DATA_W/8-1:0] byteenable2,
  input  logic [DATA_W-1:0]   readdata2
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          sel_q, sel_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                pass_q, pass_d;
  logic                cmp_valid_q;
  logic [ADDR_W-1:0]   cmp_addr_q;

  // Registered RAM-side outputs and status, loaded from next-state values
  // so every output comes straight from a flop.
  logic                busy_q, busy_d, done_q, done_d;
  logic                cs_q, cs_d, cs2_q, cs2_d;
  logic [ADDR_W-1:0]   address_q, address_d, address2_q, address2_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d, be2_q, be2_d;

  logic [DATA_W-1:0]   wr_pat, exp_pat;
  logic                mismatch;

  ram_bist_patgen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_patgen_wr (
    .addr_i (addr_d),
    .sel_i  (sel_d),
    .pat_o  (wr_pat)
  );

  ram_bist_patgen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_patgen_cmp (
    .addr_i (cmp_addr_q),
    .sel_i  (sel_q),
    .pat_o  (exp_pat)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sel_q   <= PAT_ZERO;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          addr_d  = '0;
          sel_d   = pattern_sel;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) state_d = S_READ;
      end
      S_READ: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
      end
      S_DRAIN:  state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic, evaluated on the next state
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
    cs_d       = 1'b0;
    address_d  = '0;
    wdata_d    = '0;
    be_d       = '0;
    cs2_d      = 1'b0;
    address2_d = '0;
    be2_d      = '0;
    if (state_d == S_WRITE) begin
      cs_d      = 1'b1;
      address_d = addr_d;
      wdata_d   = wr_pat;
      be_d      = '1;
    end
    if (state_d == S_READ) begin
      cs2_d      = 1'b1;
      address2_d = addr_d;
      be2_d      = '1;
    end
  end

  // Read data belongs to the address issued one cycle earlier.
  assign mismatch = cmp_valid_q && (readdata2 != exp_pat);

  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    if (state_q == S_IDLE && start) begin
      err_d   = '0;
      first_d = '0;
      pass_d  = 1'b0;
    end else if (mismatch) begin
      err_d = err_q + 1'b1;
      if (err_q == '0) first_d = cmp_addr_q;
    end
    if (state_d == S_FINISH) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_q        <= 1'b0;
      address_q   <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cs2_q       <= 1'b0;
      address2_q  <= '0;
      be2_q       <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      err_q       <= '0;
      first_q     <= '0;
      pass_q      <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_q        <= cs_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cs2_q       <= cs2_d;
      address2_q  <= address2_d;
      be2_q       <= be2_d;
      cmp_valid_q <= cs2_q;
      cmp_addr_q  <= address2_q;
      err_q       <= err_d;
      first_q     <= first_d;
      pass_q      <= pass_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign address        = address_q;
  assign chipselect     = cs_q;
  assign write          = cs_q;
  assign clken          = cs_q;
  assign writedata      = wdata_q;
  assign byteenable     = be_q;
  assign address2       = address2_q;
  assign chipselect2    = cs2_q;
  assign write2         = 1'b0;
  assign clken2         = cs2_q;
  assign writedata2     = '0;
  assign byteenable2    = be2_q;

endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Built-in self-test sequencer for the 64 x 512-bit dual-port on-chip RAM in the memory_tests system. On `start` it fills the whole RAM with a selectable data pattern through port 1, reads every word back through port 2, and compares each word. It reports pass/fail, the error count and the first failing address. It sits between the test-control registers and the RAM's two slave ports, and it is the only master of those ports while `busy` is high.

## Interface
- `ADDR_W`, 6: RAM address width; depth = 2**ADDR_W.
- `DATA_W`, 512: RAM word width; multiple of 8.
- `clk` in 1: single clock, shared with the RAM's `clk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a test; sampled only in IDLE.
- `pattern_sel` in 2: 0 = all-zeros, 1 = all-ones, 2 = checkerboard, 3 = address-in-data; latched at start.
- `busy` out 1: test in progress.
- `done` out 1: one-cycle pulse at test end.
- `pass` out 1: last test had zero mismatches; held until next start.
- `err_count` out ADDR_W+1: number of mismatching words in the last test.
- `first_err_addr` out ADDR_W: lowest failing address; valid when `pass`=0 after `done`.
- `address`, `chipselect`, `write`, `clken` out ADDR_W/1/1/1; `writedata` out DATA_W; `byteenable` out DATA_W/8: RAM port 1, write-only use.
- `address2`, `chipselect2`, `write2`, `clken2` out ADDR_W/1/1/1; `writedata2` out DATA_W; `byteenable2` out DATA_W/8: RAM port 2, read-only use; `write2`=0 and `writedata2`=0 always.
- `readdata2` in DATA_W: RAM port 2 read data.

## Operation
- FSM states: IDLE -> WRITE -> READ -> DRAIN -> FINISH -> IDLE.
- IDLE
  - All RAM controls are deasserted.
  - When `start`=1, latch `pattern_sel`, clear `err_count`, `first_err_addr` and `pass`, set `addr_cnt`=0, go to WRITE.
- WRITE
  - Drive `chipselect`=`write`=`clken`=1, `address`=`addr_cnt`, `writedata`=pattern(`addr_cnt`), `byteenable` all ones.
  - `addr_cnt` increments each cycle. At `addr_cnt`=DEPTH-1 it wraps to 0 and the FSM goes to READ.
- READ
  - Drive `chipselect2`=`clken2`=1, `address2`=`addr_cnt`, increment each cycle.
  - A 1-cycle-delayed copy of the address and a valid bit feed the compare stage.
  - After DEPTH-1, go to DRAIN.
- DRAIN
  - Port 2 is idle. This cycle compares the last word.
  - Go to FINISH.
- FINISH
  - `done`=1 for one cycle.
  - `pass` = (`err_count`==0).
  - Go to IDLE.
- Compare rule: when the valid bit is set and `readdata2` != pattern(delayed addr), `err_count` increments. `first_err_addr` is captured only on the first mismatch.
- Patterns; byte k of word at address a:
  - 0: 8'h00.
  - 1: 8'hFF.
  - 2: 8'hAA when a is even, 8'h55 when a is odd.
  - 3: {2'b00, a} XOR k[7:0].
- Width rule: `err_count` is ADDR_W+1 bits, so it holds DEPTH without saturation.
- `start` while busy is ignored.

## Timing
- RAM read latency is 1: address is registered in the RAM and q is unregistered. Data for `address2` driven in cycle N is sampled at the end of cycle N+1.
- `start` is high at edge t. Then `busy`=1 from t+1 through the FINISH cycle.
- Total run: DEPTH write + DEPTH read + 1 drain + 1 finish = 130 cycles for DEPTH=64.
- `done` and the final `pass` / `err_count` are visible in the same cycle.
- Reset values:
  - `busy`, `done`, `pass` = 0; `err_count` = 0; `first_err_addr` = 0.
  - All `chipselect*`, `write*`, `clken*` = 0; addresses, `writedata*`, `byteenable*` = 0.
  - FSM = IDLE.
- Reset mid-test: all outputs return to reset values asynchronously, so the RAM stops being written immediately. No `done` pulse is produced. RAM contents are undefined.
- All RAM-side outputs are registered. No combinational path runs from `readdata2` to any output.

## Structure
- Package `ram_bist_pkg`: state enum, pattern code constants (`PAT_ZERO`, `PAT_ONE`, `PAT_CHECK`, `PAT_ADDR`), default `ADDR_W`/`DATA_W`.
- Sub-module `ram_bist_patgen`: combinational generator of pattern(addr, sel). It is instantiated twice: once for write data, once for the compare expectation.

## Test plan
- Reset, then `start` with `pattern_sel`=0 against a fault-free RAM model -> `busy` for 130 cycles, `done` pulse, `pass`=1, `err_count`=0.
- Pattern 3, then peek the RAM model -> word 0x15 byte 0 = 8'h15, byte 1 = 8'h14; then `pass`=1.
- Model forces bit 300 stuck-at-1 at addresses 0x07 and 0x30, pattern 0 -> `pass`=0, `err_count`=2, `first_err_addr`=0x07.
- Model corrupts every read, pattern 1 -> `err_count`=64, `first_err_addr`=0.
- `start` pulsed again at cycle 20 of a run -> ignored; exactly one `done` after 130 cycles.
- `reset_n` low during READ -> all RAM controls 0 within the same cycle. After release, `busy`=0 and no `done`; a new `start` completes normally with `pass`=1.
